// File: rtl/frame_pkg.sv
// Shared definitions for the frame serializer: default field widths, the
// payload width derivation, FSM state encoding and serial line levels.
package frame_pkg;

  localparam int PORT_W_DEF = 2;
  localparam int LEN_W_DEF  = 4;

  // The length field can express 0..2**len_w-1, so that is the widest payload.
  function automatic int data_w(input int len_w);
    return (1 << len_w) - 1;
  endfunction

  localparam int DATA_W_DEF = data_w(LEN_W_DEF);

  typedef enum logic [2:0] {
    IDLE,
    START,
    PORT,
    LEN,
    DATA,
    GAP
  } state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/frame_serializer_if.sv
// Frame request channel between a producer and the serializer.
//   in_valid  producer -> serializer  request present
//   in_ready  serializer -> producer  serializer can take a request
//   in_port   producer -> serializer  destination port
//   in_len    producer -> serializer  number of payload bits
//   in_data   producer -> serializer  payload, right-aligned
interface frame_serializer_if #(
  parameter int PORT_W = frame_pkg::PORT_W_DEF,
  parameter int LEN_W  = frame_pkg::LEN_W_DEF,
  parameter int DATA_W = frame_pkg::data_w(LEN_W)
);

  logic              in_valid;
  logic              in_ready;
  logic [PORT_W-1:0] in_port;
  logic [LEN_W-1:0]  in_len;
  logic [DATA_W-1:0] in_data;

  modport master (
    output in_valid, in_port, in_len, in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_port, in_len, in_data,
    output in_ready
  );

endinterface

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register, MSB first.
//   clk, rst  clock and asynchronous active-high reset
//   en        qualifies both load and shift
//   load      capture din (takes priority over shift)
//   shift     move contents one place towards the MSB
//   din       parallel load value
//   msb       current most significant bit
module piso_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      if (load) begin
        q <= din;
      end else if (shift) begin
        q <= {q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign msb = q[WIDTH-1];

endmodule

// File: rtl/frame_serializer.sv
// Serializes one frame request onto an idle-high line as
// start bit, port field, length field, payload, all MSB first, advancing
// only on clk_en cycles.
//   clk, rst    clock and asynchronous active-high reset
//   clk_en      bit-rate enable
//   req         frame request channel (slave side)
//   ser_out     registered serial line
//   busy        high whenever not IDLE
//   frame_done  one-clk pulse after the last payload bit
//
// state | meaning
// IDLE  | line high, ready for a request
// START | start bit on the line
// PORT  | port field bits on the line
// LEN   | length field bits on the line
// DATA  | payload bits on the line
// GAP   | line high for MIN_IDLE bit periods before accepting again
module frame_serializer #(
  parameter int PORT_W   = frame_pkg::PORT_W_DEF,
  parameter int LEN_W    = frame_pkg::LEN_W_DEF,
  parameter int DATA_W   = frame_pkg::data_w(LEN_W),
  parameter int MIN_IDLE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_en,
  frame_serializer_if.slave   req,
  output logic                ser_out,
  output logic                busy,
  output logic                frame_done
);

  import frame_pkg::*;

  localparam int SR_W    = PORT_W + LEN_W + DATA_W;
  localparam int MAX_A   = (PORT_W > LEN_W) ? PORT_W : LEN_W;
  localparam int MAX_B   = (MAX_A > DATA_W) ? MAX_A : DATA_W;
  localparam int CNT_MAX = (MAX_B > MIN_IDLE) ? MAX_B : MIN_IDLE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [LEN_W-1:0]  len_q;
  logic [DATA_W-1:0] data_aligned;
  logic [SR_W-1:0]   sr_din;
  logic              sr_msb;
  logic              sr_shift;
  logic              xfer;

  assign req.in_ready = (state == IDLE);
  assign busy         = (state != IDLE);
  assign xfer         = clk_en & req.in_valid & req.in_ready;

  // Left-align the payload so its first bit sits directly behind the length field.
  assign data_aligned = req.in_data << (DATA_W - int'(req.in_len));
  assign sr_din       = {req.in_port, req.in_len, data_aligned};
  assign sr_shift     = (state != IDLE) && (state != GAP);

  piso_shift_reg #(
    .WIDTH(SR_W)
  ) u_sr (
    .clk  (clk),
    .rst  (rst),
    .en   (clk_en),
    .load (xfer),
    .shift(sr_shift),
    .din  (sr_din),
    .msb  (sr_msb)
  );

  // ser_out is loaded with the bit for the period that starts at this edge,
  // so each field's first bit is driven on the edge that enters it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      len_q      <= '0;
      ser_out    <= LINE_IDLE;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (clk_en) begin
        unique case (state)
          IDLE: begin
            if (req.in_valid) begin
              len_q <= req.in_len;
              // Zero-length requests are consumed without touching the line.
              if (req.in_len != '0) begin
                state   <= START;
                ser_out <= LINE_START;
              end
            end
          end
          START: begin
            state   <= PORT;
            cnt     <= CNT_W'(PORT_W);
            ser_out <= sr_msb;
          end
          PORT: begin
            ser_out <= sr_msb;
            if (cnt == CNT_ONE) begin
              state <= LEN;
              cnt   <= CNT_W'(LEN_W);
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          LEN: begin
            ser_out <= sr_msb;
            if (cnt == CNT_ONE) begin
              state <= DATA;
              cnt   <= CNT_W'(len_q);
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          DATA: begin
            if (cnt == CNT_ONE) begin
              state      <= GAP;
              cnt        <= CNT_W'(MIN_IDLE);
              ser_out    <= LINE_IDLE;
              frame_done <= 1'b1;
            end else begin
              ser_out <= sr_msb;
              cnt     <= cnt - CNT_ONE;
            end
          end
          GAP: begin
            // <= also covers MIN_IDLE of zero.
            if (cnt <= CNT_ONE) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          default: begin
            state   <= IDLE;
            ser_out <= LINE_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_serializer.sv
module tb_frame_serializer;

  localparam int PORT_W   = 2;
  localparam int LEN_W    = 4;
  localparam int DATA_W   = 15;
  localparam int MIN_IDLE = 1;

  typedef struct {
    logic [63:0] bits;
    int          n;
    int          gap;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_en = 1'b1;
  logic ser_out, busy, frame_done;

  int n_tests = 0;
  int n_fail  = 0;
  int en_mode = 0;
  int en_div  = 0;

  frame_t exp_q[$];
  frame_t cur;
  bit     mon_in_frame = 0;
  int     mon_idx = 0;
  int     gap_cnt = 1000;
  logic   prev_line = 1'b1;

  frame_serializer_if #(.PORT_W(PORT_W), .LEN_W(LEN_W), .DATA_W(DATA_W)) ifc ();

  frame_serializer #(
    .PORT_W(PORT_W), .LEN_W(LEN_W), .DATA_W(DATA_W), .MIN_IDLE(MIN_IDLE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .req       (ifc),
    .ser_out   (ser_out),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    case (en_mode)
      0: clk_en = 1'b1;
      1: begin
        en_div = (en_div == 2) ? 0 : en_div + 1;
        clk_en = (en_div == 0);
      end
      default: clk_en = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference line image of a frame: start, port, length, payload[len-1:0].
  function automatic frame_t make_frame(input logic [31:0] port, input logic [31:0] len,
                                        input logic [14:0] data, input int gap);
    frame_t f;
    f.bits = '0;
    f.n    = 0;
    f.gap  = gap;
    f.bits[f.n] = 1'b0;
    f.n++;
    for (int i = PORT_W - 1; i >= 0; i--) begin
      f.bits[f.n] = port[i];
      f.n++;
    end
    for (int i = LEN_W - 1; i >= 0; i--) begin
      f.bits[f.n] = len[i];
      f.n++;
    end
    for (int i = int'(len) - 1; i >= 0; i--) begin
      f.bits[f.n] = data[i];
      f.n++;
    end
    return f;
  endfunction

  // Monitor: follows the line one bit period at a time against queued frames.
  always @(posedge clk) begin
    logic en_s;
    logic fd_exp;
    en_s = clk_en;
    #1;
    fd_exp = 1'b0;
    if (rst) begin
      mon_in_frame = 0;
      gap_cnt      = 1000;
    end else if (en_s) begin
      if (mon_in_frame) begin
        if (mon_idx < cur.n) begin
          check("line_bit", ser_out, cur.bits[mon_idx]);
          check("busy_in_frame", busy, 1'b1);
          check("ready_in_frame", ifc.in_ready, 1'b0);
          mon_idx++;
        end else begin
          check("line_high_after_frame", ser_out, 1'b1);
          fd_exp       = 1'b1;
          mon_in_frame = 0;
          gap_cnt      = 1;
        end
      end else if (ser_out == 1'b0) begin
        check("start_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          if (cur.gap >= 0) check("gap_exact", gap_cnt, cur.gap);
          else              check("gap_min", gap_cnt >= MIN_IDLE + 1, 1'b1);
          mon_in_frame = 1;
          mon_idx      = 1;
        end
      end else if (gap_cnt < 1000) begin
        gap_cnt++;
      end
    end else begin
      check("hold_without_en", ser_out, prev_line);
    end
    if (fd_exp || frame_done) check("frame_done", frame_done, fd_exp);
    prev_line = ser_out;
  end

  task automatic send(input logic [31:0] port, input logic [31:0] len,
                      input logic [14:0] data, input int gap);
    int k;
    @(negedge clk);
    ifc.in_valid = 1'b1;
    ifc.in_port  = port[PORT_W-1:0];
    ifc.in_len   = len[LEN_W-1:0];
    ifc.in_data  = data;
    for (k = 0; k < 1000; k++) begin
      @(posedge clk);
      if (clk_en && ifc.in_ready) break;
    end
    check("handshake", k < 1000, 1'b1);
    if (k < 1000 && len != 0) exp_q.push_back(make_frame(port, len, data, gap));
  endtask

  task automatic idle_wait();
    int k;
    @(negedge clk);
    ifc.in_valid = 1'b0;
    ifc.in_port  = PORT_W'($urandom);
    ifc.in_len   = LEN_W'($urandom);
    ifc.in_data  = DATA_W'($urandom);
    for (k = 0; k < 2000; k++) begin
      if (ifc.in_ready && !mon_in_frame && exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("return_to_idle", k < 2000, 1'b1);
  endtask

  initial begin
    ifc.in_valid = 1'b0;
    ifc.in_port  = '0;
    ifc.in_len   = '0;
    ifc.in_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_ser_out", ser_out, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", ifc.in_ready, 1'b1);
    check("rst_frame_done", frame_done, 1'b0);
    rst = 1'b0;

    // Single frame, full rate: 0,10,0011,101.
    en_mode = 0;
    send(2, 3, 15'b101, -1);
    idle_wait();

    // Same frame, one enabled cycle in three.
    en_mode = 1;
    send(2, 3, 15'b101, -1);
    idle_wait();

    // Zero length: consumed, no line activity.
    en_mode = 0;
    send(1, 0, 15'h1234, -1);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("zero_len_busy", busy, 1'b0);
      check("zero_len_line", ser_out, 1'b1);
      @(negedge clk);
    end

    // Back-to-back at full length; fields change while frame 1 is on the line.
    send(3, 15, 15'h7FFF, -1);
    send(0, 1, 15'h0001, MIN_IDLE + 1);
    idle_wait();

    // Reset in the middle of the length field.
    send(1, 5, 15'h0015, -1);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_ser_out", ser_out, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_ready", ifc.in_ready, 1'b1);
    check("midrst_frame_done", frame_done, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send(2, 6, 15'h0029, -1);
    idle_wait();

    // Randomized frames, enable patterns and valid gaps.
    for (int t = 0; t < 30; t++) begin
      int len;
      en_mode = $urandom_range(0, 2);
      len = (t % 10 == 0) ? 15 : $urandom_range(0, 15);
      send($urandom_range(0, 3), len, 15'($urandom), -1);
      if ($urandom_range(0, 1) == 1) idle_wait();
    end
    idle_wait();

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
